// File: rtl/rs_line_packer.sv
// rs_line_packer
// Packs the byte stream coming out of the RS decoder into fixed-size lines
// and buffers completed lines in a small FIFO for a downstream consumer.
//
// Parameters
//   LINE_BYTES : bytes per output line (power of two, 2..64)
//   FIFO_DEPTH : completed lines buffered (power of two, 2..16)
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous active-high reset
//   byte_in    : decoded byte
//   byte_valid : byte_in qualifier, never back-pressured
//   flush      : single-cycle request to close a partial line
//   line_out   : head-of-FIFO line, byte k in bits [8k+7:8k]
//   line_valid : line_out holds a line
//   line_ready : consumer accepts line_out while line_valid is high
//   line_count : lines handed off, wraps modulo 2^32
//   overflow   : sticky, a completed line was dropped on a full FIFO
//   busy       : partial line held or FIFO non-empty
module rs_line_packer #(
  parameter int LINE_BYTES = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              byte_in,
  input  logic                    byte_valid,
  input  logic                    flush,
  output logic [8*LINE_BYTES-1:0] line_out,
  output logic                    line_valid,
  input  logic                    line_ready,
  output logic [31:0]             line_count,
  output logic                    overflow,
  output logic                    busy
);

  localparam int LW   = 8 * LINE_BYTES;
  localparam int CW   = $clog2(LINE_BYTES);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int NW   = PW + 1;
  localparam logic [CW-1:0] LAST_POS  = CW'(LINE_BYTES - 1);
  localparam logic [NW-1:0] FULL_CNT  = NW'(FIFO_DEPTH);

  // Registered state
  logic [CW-1:0] fill_r;
  logic [LW-1:0] asm_r;
  logic [LW-1:0] mem_r [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [NW-1:0] count_r;
  logic          valid_r;
  logic [31:0]   line_count_r;
  logic          overflow_r;

  // Combinational helpers
  logic [LW-1:0] asm_s;
  logic          complete_s;
  logic          close_s;
  logic          pop_s;
  logic          full_s;
  logic          push_s;
  logic          drop_s;
  logic [NW-1:0] count_next_s;

  // Merge the incoming byte into the line under assembly and decide whether it closes
  always_comb begin
    asm_s = asm_r;
    if (byte_valid) begin
      asm_s[{fill_r, 3'b000} +: 8] = byte_in;
    end else begin
      asm_s = asm_r;
    end
    complete_s = byte_valid && (fill_r == LAST_POS);
    // A flush on an empty assembly only closes if a byte arrives with it
    close_s    = complete_s || (flush && ((fill_r != {CW{1'b0}}) || byte_valid));
    pop_s      = valid_r && line_ready;
    full_s     = (count_r == FULL_CNT);
    // A simultaneous pop frees the slot, so a full FIFO can still take a push
    push_s     = close_s && (!full_s || pop_s);
    drop_s     = close_s && full_s && !pop_s;
  end

  // Next FIFO occupancy from push/pop pair
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + NW'(1);
      2'b01:   count_next_s = count_r - NW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Fill counter and assembly register; cleared whenever a line leaves (pushed or dropped)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_r <= {CW{1'b0}};
      asm_r  <= {LW{1'b0}};
    end else if (close_s) begin
      fill_r <= {CW{1'b0}};
      asm_r  <= {LW{1'b0}};
    end else if (byte_valid) begin
      fill_r <= fill_r + CW'(1);
      asm_r  <= asm_s;
    end else begin
      fill_r <= fill_r;
      asm_r  <= asm_r;
    end
  end

  // FIFO storage; contents are never observed without a matching valid entry, so no reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= asm_s;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // FIFO pointers, occupancy and registered valid flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {NW{1'b0}};
      valid_r  <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r <= count_next_s;
      valid_r <= (count_next_s != {NW{1'b0}});
    end
  end

  // Handoff counter, wraps naturally at 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_count_r <= 32'd0;
    end else if (pop_s) begin
      line_count_r <= line_count_r + 32'd1;
    end else begin
      line_count_r <= line_count_r;
    end
  end

  // Sticky overflow flag, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  // Head line is masked to zero while empty so reset shows an all-zero line immediately
  assign line_out   = valid_r ? mem_r[rd_ptr_r] : {LW{1'b0}};
  assign line_valid = valid_r;
  assign line_count = line_count_r;
  assign overflow   = overflow_r;
  assign busy       = (fill_r != {CW{1'b0}}) || (count_r != {NW{1'b0}});

endmodule
